// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline constants: instruction codes, register indices,
// status codes and the bubble contents loaded into pipeline registers.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RRSP  = 4'h4;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   localparam logic [2:0] BUBBLE_STAT  = STAT_AOK;
   localparam logic [3:0] BUBBLE_ICODE = I_NOP;
   localparam logic [3:0] BUBBLE_IFUN  = 4'h0;
   localparam logic [3:0] BUBBLE_REG   = RNONE;

endpackage

// File: rtl/decode_fwd_mux.sv
// Priority forwarding mux for one decode operand: youngest producer wins,
// falling back to register-file data when nothing in flight targets i_src.
module decode_fwd_mux #(
   parameter int         WIDTH = 64,
   parameter logic [3:0] RNONE = 4'hF
) (
   input  logic [3:0]       i_src,
   input  logic [3:0]       i_e_dstE,
   input  logic [WIDTH-1:0] i_e_valE,
   input  logic [3:0]       i_M_dstM,
   input  logic [WIDTH-1:0] i_m_valM,
   input  logic [3:0]       i_M_dstE,
   input  logic [WIDTH-1:0] i_M_valE,
   input  logic [3:0]       i_W_dstM,
   input  logic [WIDTH-1:0] i_W_valM,
   input  logic [3:0]       i_W_dstE,
   input  logic [WIDTH-1:0] i_W_valE,
   input  logic [WIDTH-1:0] i_rf_val,
   output logic [WIDTH-1:0] o_val
);

   logic w_valid;

   // RNONE must never alias an idle stage whose destination is also RNONE.
   assign w_valid = (i_src != RNONE);

   always_comb begin
      o_val = i_rf_val;
      if (w_valid) begin
         if (i_src == i_e_dstE)      o_val = i_e_valE;
         else if (i_src == i_M_dstM) o_val = i_m_valM;
         else if (i_src == i_M_dstE) o_val = i_M_valE;
         else if (i_src == i_W_dstM) o_val = i_W_valM;
         else if (i_src == i_W_dstE) o_val = i_W_valE;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode stage: register index decode, operand forwarding and the
// E pipeline register with hazard-unit stall/bubble control.
module decode_stage
   import y86_pkg::*;
#(
   parameter int         WIDTH = 64,
   parameter logic [3:0] RNONE = 4'hF
) (
   input  logic             clk,
   input  logic             res,
   input  logic [2:0]       D_stat,
   input  logic [3:0]       D_icode,
   input  logic [3:0]       D_ifun,
   input  logic [3:0]       D_rA,
   input  logic [3:0]       D_rB,
   input  logic [WIDTH-1:0] D_valC,
   input  logic [WIDTH-1:0] D_valP,
   output logic [3:0]       d_srcA,
   output logic [3:0]       d_srcB,
   input  logic [WIDTH-1:0] rf_valA,
   input  logic [WIDTH-1:0] rf_valB,
   input  logic [3:0]       e_dstE,
   input  logic [WIDTH-1:0] e_valE,
   input  logic [3:0]       M_dstE,
   input  logic [3:0]       M_dstM,
   input  logic [WIDTH-1:0] M_valE,
   input  logic [WIDTH-1:0] m_valM,
   input  logic [3:0]       W_dstE,
   input  logic [3:0]       W_dstM,
   input  logic [WIDTH-1:0] W_valE,
   input  logic [WIDTH-1:0] W_valM,
   input  logic             E_stall,
   input  logic             E_bubble,
   output logic [2:0]       E_stat,
   output logic [3:0]       E_icode,
   output logic [3:0]       E_ifun,
   output logic [3:0]       E_dstE,
   output logic [3:0]       E_dstM,
   output logic [3:0]       E_srcA,
   output logic [3:0]       E_srcB,
   output logic [WIDTH-1:0] E_valC,
   output logic [WIDTH-1:0] E_valA,
   output logic [WIDTH-1:0] E_valB
);

   logic [3:0]       w_srcA, w_srcB, w_dstE, w_dstM;
   logic [WIDTH-1:0] w_fwdA, w_fwdB, w_valA;

   logic [2:0]       r_stat;
   logic [3:0]       r_icode, r_ifun, r_dstE, r_dstM, r_srcA, r_srcB;
   logic [WIDTH-1:0] r_valC, r_valA, r_valB;

   always_comb begin
      w_srcA = RNONE;
      w_srcB = RNONE;
      w_dstE = RNONE;
      w_dstM = RNONE;
      case (D_icode)
         I_RRMOVQ: begin w_srcA = D_rA; w_dstE = D_rB; end
         I_IRMOVQ: begin w_dstE = D_rB; end
         I_RMMOVQ: begin w_srcA = D_rA; w_srcB = D_rB; end
         I_MRMOVQ: begin w_srcB = D_rB; w_dstM = D_rA; end
         I_OPQ:    begin w_srcA = D_rA; w_srcB = D_rB; w_dstE = D_rB; end
         I_CALL:   begin w_srcB = RRSP; w_dstE = RRSP; end
         I_RET:    begin w_srcA = RRSP; w_srcB = RRSP; w_dstE = RRSP; end
         I_PUSHQ:  begin w_srcA = D_rA; w_srcB = RRSP; w_dstE = RRSP; end
         I_POPQ:   begin w_srcA = RRSP; w_srcB = RRSP; w_dstE = RRSP; w_dstM = D_rA; end
         default:  ;
      endcase
   end

   assign d_srcA = w_srcA;
   assign d_srcB = w_srcB;

   decode_fwd_mux #(.WIDTH(WIDTH), .RNONE(RNONE)) u_fwd_a (
      .i_src   (w_srcA),
      .i_e_dstE(e_dstE), .i_e_valE(e_valE),
      .i_M_dstM(M_dstM), .i_m_valM(m_valM),
      .i_M_dstE(M_dstE), .i_M_valE(M_valE),
      .i_W_dstM(W_dstM), .i_W_valM(W_valM),
      .i_W_dstE(W_dstE), .i_W_valE(W_valE),
      .i_rf_val(rf_valA),
      .o_val   (w_fwdA)
   );

   decode_fwd_mux #(.WIDTH(WIDTH), .RNONE(RNONE)) u_fwd_b (
      .i_src   (w_srcB),
      .i_e_dstE(e_dstE), .i_e_valE(e_valE),
      .i_M_dstM(M_dstM), .i_m_valM(m_valM),
      .i_M_dstE(M_dstE), .i_M_valE(M_valE),
      .i_W_dstM(W_dstM), .i_W_valM(W_valM),
      .i_W_dstE(W_dstE), .i_W_valE(W_valE),
      .i_rf_val(rf_valB),
      .o_val   (w_fwdB)
   );

   // Jumps and calls carry valP down the pipe in the valA slot.
   assign w_valA = (D_icode == I_JXX || D_icode == I_CALL) ? D_valP : w_fwdA;

   always_ff @(posedge clk) begin
      if (res || E_bubble) begin
         r_stat  <= BUBBLE_STAT;
         r_icode <= BUBBLE_ICODE;
         r_ifun  <= BUBBLE_IFUN;
         r_dstE  <= BUBBLE_REG;
         r_dstM  <= BUBBLE_REG;
         r_srcA  <= BUBBLE_REG;
         r_srcB  <= BUBBLE_REG;
         r_valC  <= '0;
         r_valA  <= '0;
         r_valB  <= '0;
      end else if (!E_stall) begin
         r_stat  <= D_stat;
         r_icode <= D_icode;
         r_ifun  <= D_ifun;
         r_dstE  <= w_dstE;
         r_dstM  <= w_dstM;
         r_srcA  <= w_srcA;
         r_srcB  <= w_srcB;
         r_valC  <= D_valC;
         r_valA  <= w_valA;
         r_valB  <= w_fwdB;
      end
   end

   assign E_stat  = r_stat;
   assign E_icode = r_icode;
   assign E_ifun  = r_ifun;
   assign E_dstE  = r_dstE;
   assign E_dstM  = r_dstM;
   assign E_srcA  = r_srcA;
   assign E_srcB  = r_srcB;
   assign E_valC  = r_valC;
   assign E_valA  = r_valA;
   assign E_valB  = r_valB;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a reference decode/forward model predicts
// the E register contents each cycle and the DUT output is compared after the edge.
module tb_decode_stage;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         res;
   logic [2:0]   D_stat;
   logic [3:0]   D_icode, D_ifun, D_rA, D_rB;
   logic [W-1:0] D_valC, D_valP;
   logic [3:0]   d_srcA, d_srcB;
   logic [W-1:0] rf_valA, rf_valB;
   logic [3:0]   e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
   logic [W-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;
   logic         E_stall, E_bubble;
   logic [2:0]   E_stat;
   logic [3:0]   E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
   logic [W-1:0] E_valC, E_valA, E_valB;

   typedef struct packed {
      logic [2:0]   stat;
      logic [3:0]   icode, ifun, dstE, dstM, srcA, srcB;
      logic [W-1:0] valC, valA, valB;
   } exp_t;

   exp_t sb_q[$];
   exp_t m_e;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   decode_stage #(.WIDTH(W), .RNONE(4'hF)) dut (
      .clk(clk), .res(res),
      .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
      .D_valC(D_valC), .D_valP(D_valP),
      .d_srcA(d_srcA), .d_srcB(d_srcB),
      .rf_valA(rf_valA), .rf_valB(rf_valB),
      .e_dstE(e_dstE), .e_valE(e_valE),
      .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
      .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
      .E_stall(E_stall), .E_bubble(E_bubble),
      .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
      .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
      .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB)
   );

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   function automatic exp_t bubble_val();
      exp_t b;
      b.stat = 3'd1; b.icode = 4'h1; b.ifun = 4'h0;
      b.dstE = 4'hF; b.dstM = 4'hF; b.srcA = 4'hF; b.srcB = 4'hF;
      b.valC = '0; b.valA = '0; b.valB = '0;
      return b;
   endfunction

   function automatic logic [W-1:0] ref_fwd(input logic [3:0] src, input logic [W-1:0] rf);
      if (src == 4'hF)    return rf;
      if (src == e_dstE)  return e_valE;
      if (src == M_dstM)  return m_valM;
      if (src == M_dstE)  return M_valE;
      if (src == W_dstM)  return W_valM;
      if (src == W_dstE)  return W_valE;
      return rf;
   endfunction

   function automatic exp_t ref_decode();
      exp_t d;
      d.stat = D_stat; d.icode = D_icode; d.ifun = D_ifun; d.valC = D_valC;
      d.srcA = (D_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? D_rA :
               (D_icode inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
      d.srcB = (D_icode inside {4'h4, 4'h5, 4'h6}) ? D_rB :
               (D_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
      d.dstE = (D_icode inside {4'h2, 4'h3, 4'h6}) ? D_rB :
               (D_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
      d.dstM = (D_icode inside {4'h5, 4'hB}) ? D_rA : 4'hF;
      d.valA = (D_icode inside {4'h7, 4'h8}) ? D_valP : ref_fwd(d.srcA, rf_valA);
      d.valB = ref_fwd(d.srcB, rf_valB);
      return d;
   endfunction

   task automatic clear_fwd();
      e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
      e_valE = 64'hE0E0; M_valE = 64'hAE0; m_valM = 64'hAA0; W_valE = 64'hBE0; W_valM = 64'hBB0;
   endtask

   task automatic set_d(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] ra,
                        input logic [3:0] rb);
      D_stat = st; D_icode = ic; D_ifun = 4'h0; D_rA = ra; D_rB = rb;
   endtask

   // Inputs are applied 1 time unit after a rising edge; outputs sampled at the same point.
   task automatic step(input string tag);
      exp_t d, got;
      #1;
      d = ref_decode();
      check_val({tag, "_srcA"}, {60'd0, d_srcA}, {60'd0, d.srcA});
      check_val({tag, "_srcB"}, {60'd0, d_srcB}, {60'd0, d.srcB});
      if (res || E_bubble) m_e = bubble_val();
      else if (!E_stall)   m_e = d;
      sb_q.push_back(m_e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check_val({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         got = sb_q.pop_front();
         check_val({tag, "_E_stat"},  {61'd0, E_stat},  {61'd0, got.stat});
         check_val({tag, "_E_icode"}, {60'd0, E_icode}, {60'd0, got.icode});
         check_val({tag, "_E_ifun"},  {60'd0, E_ifun},  {60'd0, got.ifun});
         check_val({tag, "_E_dstE"},  {60'd0, E_dstE},  {60'd0, got.dstE});
         check_val({tag, "_E_dstM"},  {60'd0, E_dstM},  {60'd0, got.dstM});
         check_val({tag, "_E_srcA"},  {60'd0, E_srcA},  {60'd0, got.srcA});
         check_val({tag, "_E_srcB"},  {60'd0, E_srcB},  {60'd0, got.srcB});
         check_val({tag, "_E_valC"},  E_valC, got.valC);
         check_val({tag, "_E_valA"},  E_valA, got.valA);
         check_val({tag, "_E_valB"},  E_valB, got.valB);
      end
   endtask

   initial begin
      res = 1'b1; E_stall = 1'b0; E_bubble = 1'b0;
      set_d(3'd1, 4'h6, 4'h2, 4'h3);
      D_valC = 64'h1234; D_valP = 64'h2000; rf_valA = 64'h5; rf_valB = 64'h7;
      clear_fwd();
      @(posedge clk);
      step("reset");
      check_val("rst_icode", {60'd0, E_icode}, 64'd1);
      check_val("rst_stat",  {61'd0, E_stat},  64'd1);
      check_val("rst_dstE",  {60'd0, E_dstE},  64'hF);
      check_val("rst_valA",  E_valA, 64'd0);

      res = 1'b0;
      step("opq");
      check_val("opq_dstE", {60'd0, E_dstE}, 64'd3);
      check_val("opq_valA", E_valA, 64'd5);
      check_val("opq_valB", E_valB, 64'd7);

      e_dstE = 4'h2; e_valE = 64'h11; M_dstM = 4'h2; m_valM = 64'h22;
      W_dstE = 4'h2; W_valE = 64'h33;
      step("fwd_e");
      check_val("fwd_e_valA", E_valA, 64'h11);
      e_dstE = 4'hF;
      step("fwd_m");
      check_val("fwd_m_valA", E_valA, 64'h22);
      M_dstM = 4'hF;
      step("fwd_w");
      check_val("fwd_w_valA", E_valA, 64'h33);

      clear_fwd();
      set_d(3'd1, 4'hB, 4'h0, 4'hF);
      step("popq");
      check_val("popq_dstE", {60'd0, E_dstE}, 64'd4);
      check_val("popq_dstM", {60'd0, E_dstM}, 64'd0);

      set_d(3'd1, 4'h8, 4'hF, 4'hF); D_valP = 64'h40;
      e_dstE = 4'h4; e_valE = 64'hDEAD;
      step("call");
      check_val("call_valA", E_valA, 64'h40);
      check_val("call_valB", E_valB, 64'hDEAD);

      E_stall = 1'b1;
      set_d(3'd1, 4'h6, 4'h1, 4'h5);
      step("stall1");
      set_d(3'd2, 4'h3, 4'hF, 4'h9);
      step("stall2");
      check_val("stall_icode", {60'd0, E_icode}, 64'd8);
      E_bubble = 1'b1;
      step("stall_bub");
      check_val("bub_icode", {60'd0, E_icode}, 64'd1);

      E_stall = 1'b0; E_bubble = 1'b0; clear_fwd();
      set_d(3'd4, 4'hC, 4'h2, 4'h3);
      step("bad_icode");
      check_val("bad_stat", {61'd0, E_stat}, 64'd4);
      check_val("bad_dstE", {60'd0, E_dstE}, 64'hF);

      set_d(3'd2, 4'h0, 4'h2, 4'h3); rf_valA = 64'h77; e_valE = 64'h55;
      step("rnone_src");
      check_val("rnone_valA", E_valA, 64'h77);

      for (int i = 0; i < 60; i++) begin
         set_d(3'($urandom_range(1, 4)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         D_ifun  = 4'($urandom_range(0, 15));
         D_valC  = {$urandom, $urandom}; D_valP  = {$urandom, $urandom};
         rf_valA = {$urandom, $urandom}; rf_valB = {$urandom, $urandom};
         e_dstE  = 4'($urandom_range(0, 15)); M_dstE = 4'($urandom_range(0, 15));
         M_dstM  = 4'($urandom_range(0, 15)); W_dstE = 4'($urandom_range(0, 15));
         W_dstM  = 4'($urandom_range(0, 15));
         e_valE  = {$urandom, $urandom}; M_valE = {$urandom, $urandom};
         m_valM  = {$urandom, $urandom}; W_valE = {$urandom, $urandom};
         W_valM  = {$urandom, $urandom};
         E_stall  = ($urandom_range(0, 7) == 0);
         E_bubble = ($urandom_range(0, 7) == 0);
         res      = ($urandom_range(0, 15) == 0);
         step("rand");
      end

      res = 1'b1; E_stall = 1'b1; set_d(3'd1, 4'h6, 4'h1, 4'h2);
      step("mid_reset");
      check_val("mid_reset_icode", {60'd0, E_icode}, 64'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
